// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: paces moles from a slow blink clock, picks holes
// from an LFSR, and keeps a saturating BCD hit score and binary miss count.
module mole_scheduler #(
    parameter int MOLE_TICKS = 4,
    parameter int GAP_TICKS  = 1,
    parameter int ROUNDS     = 20
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic       clk_blink,
    input  logic       start,
    input  logic [3:0] btn_hit,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    localparam logic [7:0] MOLE_T  = 8'(MOLE_TICKS);
    localparam logic [7:0] GAP_T   = 8'(GAP_TICKS);
    localparam logic [7:0] ROUND_T = 8'(ROUNDS);
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       blink_prev_q, blink_prev_d;
    logic       start_prev_q, start_prev_d;
    logic [3:0] btn_prev_q, btn_prev_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [7:0] round_q, round_d;
    logic [1:0] idx_q, idx_d;
    logic       prev_valid_q, prev_valid_d;
    logic [3:0] mole_q, mole_d;
    logic [7:0] score_q, score_d;
    logic [3:0] misses_q, misses_d;
    logic       game_over_q, game_over_d;

    logic       tick;
    logic       start_edge;
    logic [3:0] btn_edge;
    logic       hit;
    logic [1:0] next_idx;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick       = clk_blink & ~blink_prev_q;
    assign start_edge = start & ~start_prev_q;
    assign btn_edge   = btn_hit & ~btn_prev_q;
    assign hit        = btn_edge[idx_q];
    // idx_q still holds the previous mole's hole while in GAP, so it doubles as the repeat guard.
    assign next_idx   = (prev_valid_q && (lfsr_q[1:0] == idx_q)) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        blink_prev_d = clk_blink;
        start_prev_d = start;
        btn_prev_d   = btn_hit;
        tick_cnt_d   = tick_cnt_q;
        round_d      = round_q;
        idx_d        = idx_q;
        prev_valid_d = prev_valid_q;
        score_d      = score_q;
        misses_d     = misses_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d      = GAP;
                    score_d      = 8'h00;
                    misses_d     = 4'd0;
                    round_d      = 8'd0;
                    tick_cnt_d   = 8'd0;
                    prev_valid_d = 1'b0;
                end
            end
            GAP: begin
                if (tick) begin
                    if (tick_cnt_q + 8'd1 == GAP_T) begin
                        state_d      = SHOW;
                        idx_d        = next_idx;
                        prev_valid_d = 1'b1;
                        tick_cnt_d   = 8'd0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            SHOW: begin
                // A hit wins over a timeout tick landing in the same cycle.
                if (hit) begin
                    score_d    = bcd_inc(score_q);
                    round_d    = round_q + 8'd1;
                    tick_cnt_d = 8'd0;
                    state_d    = (round_q + 8'd1 == ROUND_T) ? DONE : GAP;
                end else if (tick) begin
                    if (tick_cnt_q + 8'd1 == MOLE_T) begin
                        misses_d   = (misses_q == 4'hF) ? misses_q : misses_q + 4'd1;
                        round_d    = round_q + 8'd1;
                        tick_cnt_d = 8'd0;
                        state_d    = (round_q + 8'd1 == ROUND_T) ? DONE : GAP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mole_d      = (state_d == SHOW) ? (4'b0001 << idx_d) : 4'b0000;
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge master_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            blink_prev_q <= 1'b0;
            start_prev_q <= 1'b0;
            btn_prev_q   <= 4'b0000;
            tick_cnt_q   <= 8'd0;
            round_q      <= 8'd0;
            idx_q        <= 2'd0;
            prev_valid_q <= 1'b0;
            mole_q       <= 4'b0000;
            score_q      <= 8'h00;
            misses_q     <= 4'd0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            blink_prev_q <= blink_prev_d;
            start_prev_q <= start_prev_d;
            btn_prev_q   <= btn_prev_d;
            tick_cnt_q   <= tick_cnt_d;
            round_q      <= round_d;
            idx_q        <= idx_d;
            prev_valid_q <= prev_valid_d;
            mole_q       <= mole_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            game_over_q  <= game_over_d;
        end
    end

    assign mole      = mole_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: a short-game instance (ROUNDS=3) and a long-game
// instance (ROUNDS=120) share stimulus; expected moles come from a bench-side LFSR model.
module tb_mole_scheduler;

    logic       master_clk = 1'b0;
    logic       rst;
    logic       clk_blink;
    logic       start;
    logic [3:0] btn_hit;

    logic [3:0] mole1, mole2, misses1, misses2;
    logic [7:0] score1, score2;
    logic       over1, over2;

    mole_scheduler #(.MOLE_TICKS(2), .GAP_TICKS(1), .ROUNDS(3)) dut1 (
        .master_clk(master_clk), .rst(rst), .clk_blink(clk_blink), .start(start),
        .btn_hit(btn_hit), .mole(mole1), .score(score1), .misses(misses1), .game_over(over1)
    );

    mole_scheduler #(.MOLE_TICKS(2), .GAP_TICKS(1), .ROUNDS(120)) dut2 (
        .master_clk(master_clk), .rst(rst), .clk_blink(clk_blink), .start(start),
        .btn_hit(btn_hit), .mole(mole2), .score(score2), .misses(misses2), .game_over(over2)
    );

    always #5 master_clk = ~master_clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, seed A5, advancing every cycle.
    logic [7:0] m_lfsr;
    always @(posedge master_clk)
        m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    bit         use2 = 1'b0;
    logic [3:0] mole_o, misses_o;
    logic [7:0] score_o;
    logic       over_o;
    assign mole_o   = use2 ? mole2   : mole1;
    assign misses_o = use2 ? misses2 : misses1;
    assign score_o  = use2 ? score2  : score1;
    assign over_o   = use2 ? over2   : over1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic [1:0] prev_idx;
    bit         prev_valid;
    logic [1:0] cur_idx;
    logic [7:0] exp_score;
    logic [3:0] exp_misses;
    logic [3:0] last_mole;

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [3:0] u, t;
        u = v[3:0];
        t = v[7:4];
        if (t == 4'd9 && u == 4'd9) return v;
        if (u == 4'd9) return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge master_clk);
        #1;
    endtask

    task automatic do_reset(input logic hold_start);
        rst = 1'b1; clk_blink = 1'b0; start = hold_start; btn_hit = 4'b0000;
        cyc(); cyc();
        rst = 1'b0;
        exp_score = 8'h00; exp_misses = 4'd0; prev_valid = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
        exp_score = 8'h00; exp_misses = 4'd0; prev_valid = 1'b0;
        check("start_over_clear", over_o, 0);
    endtask

    // Tick in GAP: predict the hole from the model LFSR for the edge about to happen.
    task automatic gap_tick();
        logic [1:0] c;
        c = m_lfsr[1:0];
        if (prev_valid && c == prev_idx) c = c + 2'd1;
        prev_idx = c; prev_valid = 1'b1; cur_idx = c;
        exp_q.push_back(4'b0001 << c);
        clk_blink = 1'b1; cyc();
        clk_blink = 1'b0;
        check("mole_show", mole_o, exp_q.pop_front());
        cyc();
    endtask

    task automatic show_tick();
        clk_blink = 1'b1; cyc();
        clk_blink = 1'b0;
        check("mole_hold", mole_o, 4'b0001 << cur_idx);
        cyc();
    endtask

    task automatic timeout_tick();
        clk_blink = 1'b1; cyc();
        clk_blink = 1'b0;
        exp_misses = (exp_misses == 4'hF) ? exp_misses : exp_misses + 4'd1;
        check("timeout_mole", mole_o, 0);
        check("timeout_misses", misses_o, exp_misses);
        cyc();
    endtask

    task automatic hit();
        btn_hit[cur_idx] = 1'b1; cyc();
        btn_hit = 4'b0000;
        exp_score = bcd_next(exp_score);
        check("hit_mole_clear", mole_o, 0);
        check(exp_score == 8'h10 ? "bcd_carry" : "hit_score", score_o, exp_score);
        check("bcd_digits", (score_o[3:0] > 4'd9) || (score_o[7:4] > 4'd9), 0);
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset(1'b0);
        check("rst_mole", mole_o, 0);
        check("rst_score", score_o, 0);
        check("rst_misses", misses_o, 0);
        check("rst_over", over_o, 0);

        // All timeouts
        start_game();
        for (int r = 0; r < 3; r++) begin
            gap_tick(); show_tick(); timeout_tick();
        end
        check("g1_misses", misses_o, 3);
        check("g1_score", score_o, 8'h00);
        check("g1_over", over_o, 1);
        check("g1_mole", mole_o, 0);

        // Wrong button, start during SHOW, buttons in GAP, coincident hit+timeout
        start_game();
        gap_tick();
        btn_hit[cur_idx + 2'd1] = 1'b1; cyc();
        btn_hit = 4'b0000;
        check("wrong_btn_mole", mole_o, 4'b0001 << cur_idx);
        check("wrong_btn_score", score_o, exp_score);
        check("wrong_btn_misses", misses_o, exp_misses);
        cyc();
        start = 1'b1; cyc();
        start = 1'b0;
        check("start_in_show", mole_o, 4'b0001 << cur_idx);
        cyc();
        show_tick(); timeout_tick();
        btn_hit = 4'b1111; cyc();
        btn_hit = 4'b0000; cyc();
        check("gap_btn_score", score_o, 8'h00);
        check("gap_btn_mole", mole_o, 0);
        gap_tick(); show_tick();
        clk_blink = 1'b1; btn_hit[cur_idx] = 1'b1; cyc();
        clk_blink = 1'b0; btn_hit = 4'b0000;
        exp_score = bcd_next(exp_score);
        check("coinc_score", score_o, exp_score);
        check("coinc_misses", misses_o, 1);
        check("coinc_mole", mole_o, 0);
        cyc();
        gap_tick(); hit();
        check("g2_score", score_o, 8'h02);
        check("g2_over", over_o, 1);

        // All hits
        start_game();
        for (int r = 0; r < 3; r++) begin
            gap_tick(); hit();
        end
        check("g3_score", score_o, 8'h03);
        check("g3_misses", misses_o, 0);
        check("g3_over", over_o, 1);

        // Reset mid-SHOW, start held through reset release
        start_game();
        gap_tick(); hit(); gap_tick(); hit();
        gap_tick();
        check("pre_rst_score", score_o, 8'h02);
        rst = 1'b1; start = 1'b1; cyc();
        check("mid_rst_mole", mole_o, 0);
        check("mid_rst_score", score_o, 0);
        check("mid_rst_over", over_o, 0);
        check("mid_rst_lfsr", dut1.lfsr_q, 8'hA5);
        rst = 1'b0; cyc();
        start = 1'b0; cyc();
        exp_score = 8'h00; exp_misses = 4'd0; prev_valid = 1'b0;
        gap_tick(); hit();
        check("held_start_score", score_o, 8'h01);
        check("held_start_misses", misses_o, 0);

        // Long games: saturation and no repeated consecutive holes over 1080 moles
        use2 = 1'b1;
        do_reset(1'b0);
        check("rst2_score", score_o, 0);
        for (int g = 0; g < 9; g++) begin
            start_game();
            for (int r = 0; r < 120; r++) begin
                gap_tick();
                if (r > 0) check("consec_idx", mole_o == last_mole, 0);
                last_mole = mole_o;
                hit();
            end
            check("sat_score", score_o, 8'h99);
            check("long_misses", misses_o, 0);
            check("long_over", over_o, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter MOLE_TICKS, default 4, number of clk_blink rising edges a mole stays visible.
REQ-002 Parameter GAP_TICKS, default 1, number of clk_blink rising edges between moles.
REQ-003 Parameter ROUNDS, default 20, moles per game (1..255).
REQ-004 master_clk  in  1  single system clock; all logic on posedge master_clk.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 clk_blink  in  1  slow divided clock from the clock-divider stage, sampled as a level.
REQ-007 start  in  1  debounced start button, level.
REQ-008 btn_hit  in  4  debounced whack buttons, level, bit i = hole i.
REQ-009 mole  out  4  one-hot visible mole, 0 when none.
REQ-010 score  out  8  BCD hits, [7:4] tens and [3:0] units.
REQ-011 misses  out  4  binary timeouts.
REQ-012 game_over  out  1  high while in DONE.

Function
REQ-013 Tick SHALL be a one-cycle pulse on the cycle clk_blink is sampled 1 after being sampled 0 (previous-sample register).
REQ-014 start and each btn_hit bit SHALL be rising-edge detected the same way; levels are never acted on directly.
REQ-015 The 8-bit LFSR SHALL advance every master_clk cycle in all states: x^8+x^6+x^5+x^4+1, Fibonacci, shift left, seed 8'hA5, never all-zero.
REQ-016 States SHALL be IDLE, GAP, SHOW, DONE.
REQ-017 IDLE: start edge -> GAP, with score, misses, round count and tick count cleared.
REQ-018 GAP: count ticks; on tick number GAP_TICKS, latch index = lfsr[1:0], enter SHOW and clear the tick count.
REQ-019 Index SHALL never equal the previous mole's index; on a match, use (lfsr[1:0]+1) mod 4. The first mole after start has no previous index.
REQ-020 SHOW: mole SHALL equal one-hot(index), registered, asserted the cycle after entering SHOW and cleared the cycle after leaving it.
REQ-021 SHOW hit: a rising edge on btn_hit[index] -> score +1 BCD (units 9 wraps to 0 and carries), round +1, then -> GAP.
REQ-022 Edges on other btn_hit bits SHALL be ignored; edges in IDLE, GAP and DONE SHALL be ignored.
REQ-023 SHOW timeout: on tick number MOLE_TICKS with no hit -> misses +1, round +1, then -> GAP.
REQ-024 A hit and a timeout tick in the same cycle SHALL count as a hit only.
REQ-025 score SHALL saturate at 8'h99; misses SHALL saturate at 15.
REQ-026 When the round count reaches ROUNDS after a hit or timeout, the next state SHALL be DONE instead of GAP.
REQ-027 DONE: game_over=1 and mole=0; score and misses hold; a start edge behaves as in IDLE.
REQ-028 A start edge in GAP or SHOW SHALL be ignored.

Reset
REQ-029 On rst the block SHALL enter IDLE with: mole=0, score=0, misses=0, game_over=0, round and tick counts=0, LFSR=8'hA5, all edge-detect previous registers=0, previous-index valid flag cleared.
REQ-030 rst SHALL override all other inputs in the same cycle, including mid-SHOW; a start held high through rst release SHALL produce a start edge on the first cycle after release.

Verification
REQ-031 With MOLE_TICKS=2, GAP_TICKS=1, ROUNDS=3: start pulse, no buttons, 3x(1+2) ticks -> misses=3, score=8'h00, game_over=1, mole=0.
REQ-032 Same params: press btn_hit[index] once per mole -> score=8'h03, misses=0, game_over=1; each mole clears one cycle after the hit edge.
REQ-033 Press a wrong button during SHOW -> mole, score and misses unchanged; the later timeout gives misses +1.
REQ-034 Hit edge coincident with the MOLE_TICKS-th tick -> score +1, misses unchanged.
REQ-035 ROUNDS=120, all hits -> score saturates at 8'h99; BCD carry checked at 09->10; no state value is ever non-BCD.
REQ-036 rst asserted mid-SHOW with score=8'h02 -> next cycle IDLE, mole=0, score=0, LFSR=8'hA5; across any 1000 moles no two consecutive indices are equal.
